// File: rtl/multi_channel_clock_gater.sv
// multi_channel_clock_gater
//   Automatic clock gating for NUM_CH independent islands. Each channel
//   watches its own wake condition, gates its clock after IDLE_CYCLES quiet
//   cycles, and restores it through a WAKE_CYCLES-long wake phase. The gate
//   is a low-transparent latch ANDed with the root clock, so the enable can
//   only change while clk_in is low and no runt pulse can escape.
//
//   Ports
//     clk_in        root clock, all state on posedge
//     rst           synchronous active-high reset (clocks keep running)
//     gate_en       global gating enable, 0 keeps every channel running
//     ch_busy       per-channel activity
//     force_on      per-channel never-gate override
//     wake_req      level wake request, held until wake_ack
//     wake_ack      channel clock running and stable (RUN / IDLE_WAIT)
//     gated         channel in GATED
//     clk_out       gated clocks
//   Optional (macro CLKGATE_STATS_EN)
//     stats_clr     clears the gated-cycle counters
//     gated_cycles  16-bit saturating gated-cycle count per channel

`timescale 1ns/1ps

module mccg_lane #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wake_i,
`ifdef CLKGATE_STATS_EN
  input  logic        stats_clr_i,
  output logic [15:0] gated_cycles_o,
`endif
  output logic        wake_ack_o,
  output logic        gated_o,
  output logic        clk_o
);

  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {S_RUN, S_IDLE, S_GATED, S_WAKE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [WW-1:0]   wake_cnt_q, wake_cnt_d;
  logic            en_q, ack_q, gated_q;
  logic            en_lat;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      S_RUN: begin
        if (wake_i) begin
          idle_cnt_d = '0;
        end else if (IDLE_CYCLES == 1) begin
          state_d    = S_GATED;
          idle_cnt_d = '0;
        end else begin
          state_d    = S_IDLE;
          idle_cnt_d = IW'(1);
        end
      end
      S_IDLE: begin
        // wake has priority over reaching the threshold on the same edge
        if (wake_i) begin
          state_d    = S_RUN;
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_LAST) begin
          state_d    = S_GATED;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
      end
      S_GATED: begin
        if (wake_i) begin
          state_d    = S_WAKE;
          wake_cnt_d = '0;
        end
      end
      S_WAKE: begin
        // runs to completion regardless of the request
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = S_RUN;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + WW'(1);
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_RUN;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      en_q       <= 1'b1;
      ack_q      <= 1'b1;
      gated_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      en_q       <= (state_d != S_GATED);
      ack_q      <= (state_d == S_RUN) || (state_d == S_IDLE);
      gated_q    <= (state_d == S_GATED);
    end
  end

  // Enable is sampled only in the clk low phase; held through the high phase.
  always_latch begin
    if (!clk_i) en_lat = en_q;
  end

  assign clk_o      = clk_i & en_lat;
  assign wake_ack_o = ack_q;
  assign gated_o    = gated_q;

`ifdef CLKGATE_STATS_EN
  logic [15:0] gcyc_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || stats_clr_i)                   gcyc_q <= '0;
    else if (state_q == S_GATED && gcyc_q != 16'hFFFF) gcyc_q <= gcyc_q + 16'd1;
  end
  assign gated_cycles_o = gcyc_q;
`endif

endmodule

module multi_channel_clock_gater #(
  parameter int NUM_CH      = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 gate_en,
  input  logic [NUM_CH-1:0]    ch_busy,
  input  logic [NUM_CH-1:0]    force_on,
  input  logic [NUM_CH-1:0]    wake_req,
`ifdef CLKGATE_STATS_EN
  input  logic                 stats_clr,
  output logic [NUM_CH*16-1:0] gated_cycles,
`endif
  output logic [NUM_CH-1:0]    wake_ack,
  output logic [NUM_CH-1:0]    gated,
  output logic [NUM_CH-1:0]    clk_out
);

  logic [NUM_CH-1:0] w;
  assign w = ch_busy | force_on | wake_req | {NUM_CH{~gate_en}};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    mccg_lane #(
      .IDLE_CYCLES (IDLE_CYCLES),
      .WAKE_CYCLES (WAKE_CYCLES)
    ) u_lane (
      .clk_i          (clk_in),
      .rst_i          (rst),
      .wake_i         (w[g]),
`ifdef CLKGATE_STATS_EN
      .stats_clr_i    (stats_clr),
      .gated_cycles_o (gated_cycles[g*16 +: 16]),
`endif
      .wake_ack_o     (wake_ack[g]),
      .gated_o        (gated[g]),
      .clk_o          (clk_out[g])
    );
  end

endmodule
